fifo_reader: RTL and testbench

FIFO_READER -- requirements
Module: fifo_reader

---
 rtl/fifo_pkg.sv | 21 ++
 rtl/fifo_reader.sv | 83 ++++++++
 tb/tb_fifo_reader.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO and its registered read-side adapter.
// Holds the reader skid depth and the reader occupancy counter type.
package fifo_pkg;

  localparam int READER_DEPTH = 2;

  typedef logic [$clog2(READER_DEPTH+1)-1:0] occ_t;

  // Occupancy after one cycle: one word may land and one may leave.
  function automatic occ_t occ_next(input occ_t occ, input logic wr, input logic rd);
    return occ_t'(occ + occ_t'(wr) - occ_t'(rd));
  endfunction

  // A new pop is allowed only if every word already owed to the buffer still fits.
  function automatic logic room_avail(input occ_t occ, input logic inflight, input logic deq);
    logic [2:0] w_need;
    w_need = {1'b0, occ} + {2'b00, inflight} - {2'b00, deq};
    return w_need < 3'(READER_DEPTH);
  endfunction

endpackage

// File: rtl/fifo_reader.sv
// Converts a FIFO with registered read data into a valid/ready stream with a
// 2-entry skid buffer. Optional flush port enabled by macro FIFO_READER_FLUSH_EN.
module fifo_reader
  import fifo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
`ifdef FIFO_READER_FLUSH_EN
  input  logic             flush_i,
`endif
  input  logic             fifo_empty_i,
  input  logic [WIDTH-1:0] fifo_data_i,
  output logic             fifo_pop_o,
  output logic             m_valid_o,
  output logic [WIDTH-1:0] m_data_o,
  input  logic             m_ready_i
);

  logic [WIDTH-1:0] r_buf [READER_DEPTH];
  occ_t             r_occ;
  logic             r_inflight;
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic             r_run;

  logic             w_flush;
  logic             w_deq;
  logic             w_wr;
  logic             w_pop;

`ifdef FIFO_READER_FLUSH_EN
  assign w_flush = flush_i;
`else
  assign w_flush = 1'b0;
`endif

  // r_run holds off popping until the first edge after reset release.
  assign w_deq      = m_valid_o && m_ready_i;
  assign w_wr       = r_inflight && !w_flush;
  assign w_pop      = r_run && !fifo_empty_i && !w_flush
                      && room_avail(r_occ, r_inflight, w_deq);
  assign fifo_pop_o = w_pop;

  assign m_valid_o  = (r_occ != '0);
  assign m_data_o   = m_valid_o ? r_buf[r_rd_ptr] : '0;

  // Control stage: occupancy, pointers and the pop-to-data in-flight marker.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_occ      <= '0;
      r_inflight <= 1'b0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_run      <= 1'b0;
    end else begin
      r_run      <= 1'b1;
      r_inflight <= w_pop;
      if (w_flush) begin
        r_occ    <= '0;
        r_wr_ptr <= 1'b0;
        r_rd_ptr <= 1'b0;
      end else begin
        r_occ <= occ_next(r_occ, w_wr, w_deq);
        if (w_wr) begin
          r_wr_ptr <= ~r_wr_ptr;
        end
        if (w_deq) begin
          r_rd_ptr <= ~r_rd_ptr;
        end
      end
    end
  end

  // Data stage: capture the FIFO's registered read word one cycle after the pop.
  always_ff @(posedge clk_i) begin
    if (w_wr) begin
      r_buf[r_wr_ptr] <= fifo_data_i;
    end
  end

endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: behavioural FIFO source feeding the DUT, scoreboard on
// the downstream side. Flush scenario is built when FIFO_READER_FLUSH_EN is defined.
module tb_fifo_reader;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_ni = 1'b1;
  logic             fifo_empty_i;
  logic [WIDTH-1:0] fifo_data_i = '0;
  logic             fifo_pop_o;
  logic             m_valid_o;
  logic [WIDTH-1:0] m_data_o;
  logic             m_ready_i = 1'b0;
`ifdef FIFO_READER_FLUSH_EN
  logic             flush_i = 1'b0;
`endif

  fifo_reader #(.WIDTH(WIDTH)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
`ifdef FIFO_READER_FLUSH_EN
    .flush_i     (flush_i),
`endif
    .fifo_empty_i(fifo_empty_i),
    .fifo_data_i (fifo_data_i),
    .fifo_pop_o  (fifo_pop_o),
    .m_valid_o   (m_valid_o),
    .m_data_o    (m_data_o),
    .m_ready_i   (m_ready_i)
  );

  always #5 clk = ~clk;

  // Source FIFO model with registered read data.
  logic [WIDTH-1:0] mem [256];
  logic [7:0]       head = 8'd0;
  logic [7:0]       tail = 8'd0;
  int               pop_cnt = 0;
  int               under_cnt = 0;
  int               out_cnt = 0;
  logic [WIDTH-1:0] exp_q [$];
  int               n_chk = 0;
  int               n_pass = 0;

  assign fifo_empty_i = (head == tail);

  always @(posedge clk) begin
    if (fifo_pop_o) begin
      pop_cnt <= pop_cnt + 1;
      if (head == tail) begin
        under_cnt <= under_cnt + 1;
      end else begin
        fifo_data_i <= mem[head];
        head        <= head + 8'd1;
      end
    end
  end

  task automatic chk(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: every accepted output must be the oldest word still owed.
  always @(negedge clk) begin
    if (rst_ni && m_valid_o && m_ready_i) begin
      out_cnt <= out_cnt + 1;
      if (exp_q.size() == 0) begin
        chk("extra_out", 32'(m_valid_o), 32'd0);
      end else begin
        chk("out_data", m_data_o, exp_q.pop_front());
      end
    end
  end

  task automatic push_word(input logic [WIDTH-1:0] w);
    mem[tail] = w;
    tail      = tail + 8'd1;
    exp_q.push_back(w);
  endtask

  // Words already popped from the source are lost on reset/flush.
  task automatic rebuild_exp();
    exp_q.delete();
    for (logic [7:0] p = head; p != tail; p = p + 8'd1) begin
      exp_q.push_back(mem[p]);
    end
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    #1;
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int o0;
    int o1;
    int s;
    int n;

    #1 rst_ni = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(m_valid_o), 32'd0);
    chk("rst_pop",   32'(fifo_pop_o), 32'd0);
    chk("rst_data",  m_data_o, 32'd0);
    @(posedge clk); #1 rst_ni = 1'b1;
    @(posedge clk); #1;

    // Single word: pop now, visible two cycles later, one pop total.
    m_ready_i = 1'b1;
    p0 = pop_cnt;
    push_word(32'hA5A5_0001);
    #1 chk("single_pop_now", 32'(fifo_pop_o), 32'd1);
    @(negedge clk); chk("single_vld_c0", 32'(m_valid_o), 32'd0);
    @(negedge clk); chk("single_vld_c1", 32'(m_valid_o), 32'd0);
    @(negedge clk); chk("single_vld_c2", 32'(m_valid_o), 32'd1);
    chk("single_data_c2", m_data_o, 32'hA5A5_0001);
    repeat (3) @(negedge clk);
    chk("single_pops", 32'(pop_cnt - p0), 32'd1);

    // Streaming: 16 back-to-back outputs.
    @(posedge clk); #1;
    p0 = pop_cnt;
    for (int i = 0; i < 16; i++) push_word(32'h1000_0000 + 32'(i));
    n = 0;
    @(negedge clk);
    while (!m_valid_o && n < 10) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 16; i++) begin
      chk("stream_vld", 32'(m_valid_o), 32'd1);
      @(negedge clk);
    end
    chk("stream_end_vld", 32'(m_valid_o), 32'd0);
    chk("stream_pops", 32'(pop_cnt - p0), 32'd16);
    chk("stream_left", 32'(exp_q.size()), 32'd0);

    // Back-pressure: stall 10 cycles, only two pops, head word held.
    @(posedge clk); #1;
    m_ready_i = 1'b0;
    p0 = pop_cnt;
    for (int i = 0; i < 8; i++) push_word(32'h2000_0000 + 32'(i));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i >= 3) begin
        chk("bp_vld",  32'(m_valid_o), 32'd1);
        chk("bp_hold", m_data_o, 32'h2000_0000);
      end
    end
    chk("bp_stall_pops", 32'(pop_cnt - p0), 32'd2);
    @(posedge clk); #1 m_ready_i = 1'b1;
    drain("bp_drain", 60);
    chk("bp_pops", 32'(pop_cnt - p0), 32'd8);

    // Empty source: nothing popped, nothing presented.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("empty_pop", 32'(fifo_pop_o), 32'd0);
      chk("empty_vld", 32'(m_valid_o), 32'd0);
    end

    // Reset mid-stream after five words delivered.
    @(posedge clk); #1;
    o0 = out_cnt;
    for (int i = 0; i < 10; i++) push_word(32'h3000_0000 + 32'(i));
    n = 0;
    while ((out_cnt - o0) < 5 && n < 40) begin
      @(posedge clk);
      n++;
    end
    chk("rstm_reach5", 32'((out_cnt - o0) >= 5), 32'd1);
    #1 rst_ni = 1'b0;
    #1;
    chk("rstm_vld",  32'(m_valid_o), 32'd0);
    chk("rstm_pop",  32'(fifo_pop_o), 32'd0);
    chk("rstm_data", m_data_o, 32'd0);
    rebuild_exp();
    s = exp_q.size();
    repeat (3) begin
      @(negedge clk);
      chk("rstm_hold_pop", 32'(fifo_pop_o), 32'd0);
    end
    @(posedge clk); #1 rst_ni = 1'b1;
    #1 chk("rstm_release_pop", 32'(fifo_pop_o), 32'd0);
    chk("rstm_release_vld", 32'(m_valid_o), 32'd0);
    @(negedge clk);
    o1 = out_cnt;
    drain("rstm_drain", 60);
    chk("rstm_count", 32'(out_cnt - o1), 32'(s));

`ifdef FIFO_READER_FLUSH_EN
    // Flush while the first word is in flight: it is dropped, pop suppressed.
    @(posedge clk); #1;
    m_ready_i = 1'b0;
    for (int i = 0; i < 6; i++) push_word(32'h4000_0000 + 32'(i));
    @(posedge clk); #1;
    flush_i = 1'b1;
    rebuild_exp();
    #1 chk("flush_pop", 32'(fifo_pop_o), 32'd0);
    @(posedge clk); #1 flush_i = 1'b0;
    @(negedge clk);
    chk("flush_next_vld", 32'(m_valid_o), 32'd0);
    chk("flush_next_head", exp_q[0], 32'h4000_0001);
    m_ready_i = 1'b1;
    drain("flush_drain", 60);
`endif

    chk("underflow", 32'(under_cnt), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
